// File: rtl/bitonic_sort_sequencer.sv
// Multi-cycle bitonic sorter: one compare-exchange stage per clock on a registered array,
// then holds the ascending result and the requested rank until downstream consumes it.
module bitonic_sort_sequencer #(
    parameter int MAX_NUM_SIZE = 32,
    parameter int NUM_OF_NUMS  = 4
) (
    input  logic                                       clk_in,
    input  logic                                       rst_n_in,
    input  logic [NUM_OF_NUMS-1:0][MAX_NUM_SIZE-1:0]   numbers_in,
    input  logic [$clog2(NUM_OF_NUMS)-1:0]             index_in,
    input  logic                                       valid_in,
    output logic                                       ready_out,
    input  logic                                       flush_in,
    output logic [NUM_OF_NUMS-1:0][MAX_NUM_SIZE-1:0]   sorted_out,
    output logic [MAX_NUM_SIZE-1:0]                    nth_number_out,
    output logic                                       valid_out,
    input  logic                                       ready_in
);
    localparam int unsigned LOGN = $clog2(NUM_OF_NUMS);
    localparam int unsigned CW   = $clog2(LOGN + 1);

    generate
        if (NUM_OF_NUMS < 2 || (NUM_OF_NUMS & (NUM_OF_NUMS - 1)) != 0) begin : g_bad_n
            $error("bitonic_sort_sequencer: NUM_OF_NUMS must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t                                     r_state, w_state_nxt;
    logic [NUM_OF_NUMS-1:0][MAX_NUM_SIZE-1:0]   r_arr, w_arr_nxt;
    logic [LOGN-1:0]                            r_idx;
    logic [CW-1:0]                              r_p, r_q;
    logic                                       w_last_stage;
    int unsigned                                w_k, w_j;

    assign w_last_stage = (r_q == '0) && (r_p == CW'(LOGN));

    // One stage: k = 2^p selects the sort direction per block, j = 2^q the partner distance.
    always_comb begin
        int unsigned l;
        logic        up;
        w_arr_nxt = r_arr;
        w_k       = 32'd1 << r_p;
        w_j       = 32'd1 << r_q;
        l         = 0;
        up        = 1'b0;
        for (int unsigned i = 0; i < NUM_OF_NUMS; i++) begin
            l  = i ^ w_j;
            up = ((i & w_k) == 0);
            if (l > i) begin
                if ((up && r_arr[i[LOGN-1:0]] > r_arr[l[LOGN-1:0]]) ||
                    (!up && r_arr[i[LOGN-1:0]] < r_arr[l[LOGN-1:0]])) begin
                    w_arr_nxt[i[LOGN-1:0]] = r_arr[l[LOGN-1:0]];
                    w_arr_nxt[l[LOGN-1:0]] = r_arr[i[LOGN-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_in) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (valid_in)     w_state_nxt = SORT;
                SORT:    if (w_last_stage) w_state_nxt = DONE;
                DONE:    if (ready_in)     w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_arr <= '0;
            r_idx <= '0;
            r_p   <= '0;
            r_q   <= '0;
        end else if (flush_in) begin
            r_p <= '0;
            r_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_arr <= numbers_in;
                        r_idx <= index_in;
                        r_p   <= CW'(1);
                        r_q   <= '0;
                    end
                end
                SORT: begin
                    r_arr <= w_arr_nxt;
                    // Next merge level starts with j = k/2 of the new k, i.e. q = old p.
                    if (r_q == '0) begin
                        if (!w_last_stage) begin
                            r_p <= r_p + CW'(1);
                            r_q <= r_p;
                        end
                    end else begin
                        r_q <= r_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_out      = (r_state == IDLE);
    assign valid_out      = (r_state == DONE);
    assign sorted_out     = r_arr;
    assign nth_number_out = r_arr[r_idx];
endmodule

// File: tb/tb_bitonic_sort_sequencer.sv
// Directed N=4/W=32 checks plus randomized N=8/W=16 requests against a software sort.
module tb_bitonic_sort_sequencer;
    typedef logic [3:0][31:0] arr4_t;
    typedef logic [7:0][15:0] arr8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arr4_t       d4_nums, d4_sorted;
    logic [1:0]  d4_idx;
    logic        d4_vin, d4_rdy_out, d4_flush, d4_vout, d4_rin;
    logic [31:0] d4_nth;

    arr8_t       d8_nums, d8_sorted;
    logic [2:0]  d8_idx;
    logic        d8_vin, d8_rdy_out, d8_flush, d8_vout, d8_rin;
    logic [15:0] d8_nth;

    int checks = 0;
    int errors = 0;

    bitonic_sort_sequencer #(.MAX_NUM_SIZE(32), .NUM_OF_NUMS(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .numbers_in(d4_nums), .index_in(d4_idx),
        .valid_in(d4_vin), .ready_out(d4_rdy_out), .flush_in(d4_flush),
        .sorted_out(d4_sorted), .nth_number_out(d4_nth), .valid_out(d4_vout),
        .ready_in(d4_rin)
    );

    bitonic_sort_sequencer #(.MAX_NUM_SIZE(16), .NUM_OF_NUMS(8)) dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .numbers_in(d8_nums), .index_in(d8_idx),
        .valid_in(d8_vin), .ready_out(d8_rdy_out), .flush_in(d8_flush),
        .sorted_out(d8_sorted), .nth_number_out(d8_nth), .valid_out(d8_vout),
        .ready_in(d8_rin)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain insertion sort of the request values.
    function automatic arr8_t sort8(input arr8_t v);
        logic [15:0] a [8];
        logic [15:0] key;
        int j;
        for (int i = 0; i < 8; i++) a[i] = v[i];
        for (int i = 1; i < 8; i++) begin
            key = a[i];
            j = i;
            while (j > 0 && a[j-1] > key) begin
                a[j] = a[j-1];
                j--;
            end
            a[j] = key;
        end
        for (int i = 0; i < 8; i++) sort8[i] = a[i];
    endfunction

    function automatic arr4_t pack4(input logic [31:0] a0, a1, a2, a3);
        pack4[0] = a0; pack4[1] = a1; pack4[2] = a2; pack4[3] = a3;
    endfunction

    task automatic start4(input logic [31:0] a0, a1, a2, a3, input logic [1:0] idx);
        @(negedge clk);
        d4_nums = pack4(a0, a1, a2, a3);
        d4_idx  = idx;
        d4_vin  = 1'b1;
        @(negedge clk);
        d4_vin  = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 1;
        while (!d4_vout && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic job4(input logic [31:0] a0, a1, a2, a3, input logic [1:0] idx,
                        input arr4_t exp, input logic [31:0] exp_nth);
        int lat;
        start4(a0, a1, a2, a3, idx);
        wait4(lat);
        chk("lat4", 128'(lat), 128'd4);
        chk("sorted4", 128'(d4_sorted), 128'(exp));
        chk("nth4", 128'(d4_nth), 128'(exp_nth));
        @(negedge clk);
        chk("pulse4", 128'(d4_vout), 128'd0);
        chk("rdy_after4", 128'(d4_rdy_out), 128'd1);
    endtask

    initial begin
        int lat, pulses, n;
        arr8_t v, exp8;
        d4_nums = '0; d4_idx = '0; d4_vin = 1'b0; d4_flush = 1'b0; d4_rin = 1'b1;
        d8_nums = '0; d8_idx = '0; d8_vin = 1'b0; d8_flush = 1'b0; d8_rin = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_vout", 128'(d4_vout), 128'd0);
        chk("rst_sorted", 128'(d4_sorted), 128'd0);
        chk("rst_nth", 128'(d4_nth), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 128'(d4_rdy_out), 128'd1);
        chk("rst_vout8", 128'(d8_vout), 128'd0);

        job4(7, 3, 9, 1, 2'd0, pack4(1, 3, 7, 9), 32'd1);
        job4(7, 3, 9, 1, 2'd3, pack4(1, 3, 7, 9), 32'd9);
        job4(5, 5, 2, 5, 2'd1, pack4(2, 5, 5, 5), 32'd5);
        job4(32'hFFFF_FFFF, 0, 1, 2, 2'd0, pack4(0, 1, 2, 32'hFFFF_FFFF), 32'd0);

        // Backpressure: DONE held while new requests are offered.
        d4_rin = 1'b0;
        start4(7, 3, 9, 1, 2'd2);
        wait4(lat);
        chk("bp_lat", 128'(lat), 128'd4);
        for (int c = 0; c < 10; c++) begin
            d4_vin  = 1'b1;
            d4_nums = pack4(100, 200, 300, 50);
            d4_idx  = 2'd0;
            @(negedge clk);
            chk("bp_sorted", 128'(d4_sorted), 128'(pack4(1, 3, 7, 9)));
            chk("bp_nth", 128'(d4_nth), 128'd7);
            chk("bp_rdy", 128'(d4_rdy_out), 128'd0);
            chk("bp_vout", 128'(d4_vout), 128'd1);
        end
        d4_vin = 1'b0;
        d4_rin = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 128'(d4_rdy_out), 128'd1);
        chk("bp_release_vout", 128'(d4_vout), 128'd0);
        chk("bp_not_latched", 128'(d4_sorted), 128'(pack4(1, 3, 7, 9)));

        // Asynchronous reset during the second SORT cycle.
        start4(7, 3, 9, 1, 2'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vout", 128'(d4_vout), 128'd0);
        chk("mid_rst_rdy", 128'(d4_rdy_out), 128'd1);
        chk("mid_rst_arr", 128'(d4_sorted), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 128'(d4_rdy_out), 128'd1);
        job4(4, 2, 8, 6, 2'd2, pack4(2, 4, 6, 8), 32'd6);

        // Flush during SORT.
        start4(7, 3, 9, 1, 2'd1);
        d4_flush = 1'b1;
        @(negedge clk);
        d4_flush = 1'b0;
        chk("fl_sort_rdy", 128'(d4_rdy_out), 128'd1);
        chk("fl_sort_vout", 128'(d4_vout), 128'd0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (d4_vout) pulses++;
        end
        chk("fl_sort_nopulse", 128'(pulses), 128'd0);

        // Flush during DONE.
        d4_rin = 1'b0;
        start4(9, 8, 7, 6, 2'd0);
        wait4(lat);
        chk("fl_done_lat", 128'(lat), 128'd4);
        d4_flush = 1'b1;
        @(negedge clk);
        d4_flush = 1'b0;
        d4_rin = 1'b1;
        chk("fl_done_vout", 128'(d4_vout), 128'd0);
        chk("fl_done_rdy", 128'(d4_rdy_out), 128'd1);

        // valid_in coincident with flush in IDLE is dropped.
        d4_flush = 1'b1;
        d4_vin   = 1'b1;
        d4_nums  = pack4(1, 2, 3, 4);
        @(negedge clk);
        d4_flush = 1'b0;
        d4_vin   = 1'b0;
        chk("fl_idle_rdy", 128'(d4_rdy_out), 128'd1);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (d4_vout || !d4_rdy_out) pulses++;
        end
        chk("fl_idle_noaccept", 128'(pulses), 128'd0);

        // Randomized N=8 requests with random downstream stalls.
        for (int r = 0; r < 500; r++) begin
            for (int i = 0; i < 8; i++)
                v[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            exp8 = sort8(v);
            @(negedge clk);
            chk("rnd_rdy", 128'(d8_rdy_out), 128'd1);
            d8_nums = v;
            d8_idx  = 3'($urandom_range(0, 7));
            d8_vin  = 1'b1;
            d8_rin  = 1'($urandom_range(0, 1));
            @(negedge clk);
            d8_vin = 1'b0;
            lat = 1;
            while (!d8_vout && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            chk("rnd_lat", 128'(lat), 128'd7);
            chk("rnd_sorted", 128'(d8_sorted), 128'(exp8));
            chk("rnd_nth", 128'(d8_nth), 128'(exp8[d8_idx]));
            n = 0;
            while (d8_vout && n < 40) begin
                chk("rnd_hold", 128'(d8_sorted), 128'(exp8));
                d8_rin = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            chk("rnd_release", 128'(d8_vout), 128'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
